// File: rtl/projective_pixel_writer_pkg.sv
// Shared constants, the queued write-word record and the drain FSM states.
package projective_pixel_writer_pkg;

   localparam int FRAME_W        = 640;
   localparam int FRAME_H        = 480;
   localparam int WORDS_PER_LINE = 320;
   localparam int PIXEL_W        = 18;
   localparam int ADDR_W         = 19;
   localparam int DATA_W         = 2 * PIXEL_W;
   localparam int BE_W           = 2;

   // One ZBT write: {bank, line offset}, {odd pixel, even pixel}, half-word enables.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } word_t;

   localparam int WORD_W = $bits(word_t);

   typedef enum logic {
      ST_WRITE,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/projective_pixel_writer_fifo.sv
// Synchronous write-word queue; head is visible combinationally on rd_data.
module pixel_write_fifo
   import projective_pixel_writer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = WORD_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_en   = pop && !empty;
   // A full queue still takes a word when the head leaves in the same cycle.
   assign wr_en   = push && (!full || rd_en);
   assign rd_data = store[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are meaningless while the queue is empty.
   always_ff @(posedge clk) begin
      if (wr_en) store[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/projective_pixel_writer.sv
// Pairs addressed pixels into 36-bit ZBT words, queues them for the SRAM
// write port and swaps display/write banks once a frame has drained.
module projective_pixel_writer #(
   parameter int FIFO_DEPTH = 8,
   parameter int FRAME_W    = projective_pixel_writer_pkg::FRAME_W,
   parameter int FRAME_H    = projective_pixel_writer_pkg::FRAME_H
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_flag,
   input  logic        pixel_flag,
   input  logic [17:0] pixel_in,
   input  logic [9:0]  pixel_x,
   input  logic [8:0]  pixel_y,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [35:0] mem_data,
   output logic [1:0]  mem_be,
   input  logic        mem_ready,
   output logic        display_bank,
   output logic        frame_done,
   output logic        overflow,
   output logic        oob_drop
);

   import projective_pixel_writer_pkg::*;

   localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [9:0] X_LIMIT = 10'(FRAME_W);
   localparam logic [8:0] Y_LIMIT = 9'(FRAME_H);

   // y*320 built from two shifts so no multiplier is inferred.
   function automatic logic [ADDR_W-1:0] word_addr(input logic       bank,
                                                   input logic [8:0] y,
                                                   input logic [9:0] x);
      logic [17:0] row_base;
      row_base = {1'b0, y, 8'b0} + {3'b0, y, 6'b0};
      return {bank, row_base + {9'b0, x[9:1]}};
   endfunction

   logic               hold_vld;
   logic               hold_bank;
   logic [9:0]         hold_x;
   logic [8:0]         hold_y;
   logic [PIXEL_W-1:0] hold_pix;

   logic       in_range;
   logic       pix_ok;
   logic       pair_hit;
   logic       flush;
   logic       push;
   logic       push_acc;
   logic       pop;
   logic       drop;
   logic       load_hold;
   word_t      push_word;
   word_t      head_word;
   logic       fifo_full;
   logic       fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] stale_cnt;
   logic [CNT_W-1:0] stale_nxt;
   logic [CNT_W-1:0] stale_load;

   state_t state;
   state_t state_nxt;
   logic   write_bank;
   logic   wbank_nxt;
   logic   disp_nxt;
   logic   done_nxt;

   // Pairing decision and construction of the (single) word enqueued this cycle.
   always_comb begin
      in_range  = (pixel_x < X_LIMIT) && (pixel_y < Y_LIMIT);
      pix_ok    = pixel_flag && in_range;
      // A frame boundary never pairs: the held pixel belongs to the old bank.
      pair_hit  = pix_ok && !frame_flag && hold_vld &&
                  (pixel_y == hold_y) && (pixel_x[9:1] == hold_x[9:1]) &&
                  (pixel_x[0] != hold_x[0]);
      flush     = hold_vld && !pair_hit && (frame_flag || pix_ok);
      push      = pair_hit || flush;
      load_hold = pix_ok && !pair_hit;

      push_word      = '0;
      push_word.addr = word_addr(hold_bank, hold_y, hold_x);
      if (pair_hit) begin
         push_word.data = pixel_x[0] ? {pixel_in, hold_pix} : {hold_pix, pixel_in};
         push_word.be   = 2'b11;
      end else if (hold_x[0]) begin
         push_word.data = {hold_pix, {PIXEL_W{1'b0}}};
         push_word.be   = 2'b10;
      end else begin
         push_word.data = {{PIXEL_W{1'b0}}, hold_pix};
         push_word.be   = 2'b01;
      end
   end

   assign pop        = !fifo_empty && mem_ready;
   assign push_acc   = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;
   // Words belonging to the closing frame: what stays queued after this edge.
   assign stale_load = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);

   pixel_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_acc),
      .wr_data (push_word),
      .pop     (pop),
      .rd_data (head_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign mem_we   = !fifo_empty;
   assign mem_addr = fifo_empty ? '0 : head_word.addr;
   assign mem_data = fifo_empty ? '0 : head_word.data;
   assign mem_be   = fifo_empty ? '0 : head_word.be;

   // Drain FSM: bank swap on frame_flag, display update once old words are gone.
   always_comb begin
      state_nxt = state;
      stale_nxt = stale_cnt;
      wbank_nxt = write_bank;
      disp_nxt  = display_bank;
      done_nxt  = 1'b0;
      if (frame_flag) begin
         wbank_nxt = ~write_bank;
         if (stale_load == '0) begin
            state_nxt = ST_WRITE;
            stale_nxt = '0;
            disp_nxt  = write_bank;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = ST_DRAIN;
            stale_nxt = stale_load;
         end
      end else if ((state == ST_DRAIN) && pop) begin
         if (stale_cnt == CNT_W'(1)) begin
            state_nxt = ST_WRITE;
            stale_nxt = '0;
            disp_nxt  = ~write_bank;
            done_nxt  = 1'b1;
         end else begin
            stale_nxt = stale_cnt - 1'b1;
         end
      end
   end

   // Control state: FSM, banks, hold occupancy and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_WRITE;
         stale_cnt    <= '0;
         write_bank   <= 1'b0;
         display_bank <= 1'b1;
         frame_done   <= 1'b0;
         overflow     <= 1'b0;
         oob_drop     <= 1'b0;
         hold_vld     <= 1'b0;
      end else begin
         state        <= state_nxt;
         stale_cnt    <= stale_nxt;
         write_bank   <= wbank_nxt;
         display_bank <= disp_nxt;
         frame_done   <= done_nxt;
         oob_drop     <= pixel_flag && !in_range;
         if (drop)            overflow <= 1'b1;
         else if (frame_flag) overflow <= 1'b0;
         if (load_hold)                   hold_vld <= 1'b1;
         else if (frame_flag || pair_hit) hold_vld <= 1'b0;
      end
   end

   // Hold register payload; only meaningful while hold_vld is set.
   always_ff @(posedge clk) begin
      if (load_hold) begin
         hold_x    <= pixel_x;
         hold_y    <= pixel_y;
         hold_pix  <= pixel_in;
         hold_bank <= frame_flag ? ~write_bank : write_bank;
      end
   end

endmodule
